// File: rtl/mem_sram_ctrl.sv
// Asynchronous-SRAM controller: one read or write per CPU strobe, registered pin timing.
// Optional sticky protocol-error flag Err is compiled in with `define MEM_SRAM_CTRL_ERR_EN.
module mem_sram_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic [15:0] SRAM_DQ_in,
    output logic [15:0] Data_to_CPU,
    output logic        Rd_valid,
    output logic        Busy,
    output logic [19:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_out,
    output logic        SRAM_DQ_oe,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
`ifdef MEM_SRAM_CTRL_ERR_EN
    ,
    output logic        Err
`endif
);

    localparam logic [3:0] WAIT_LD = WAIT_CYCLES[3:0];

    typedef enum logic [2:0] {IDLE, READ, WRITE, WREC, RREC} state_t;

    state_t      state, state_n;
    logic        armed, armed_n;
    logic [3:0]  cnt, cnt_n;
    logic        busy_n, rdv_n, dqoe_n, oen_n, wen_n;
    logic [15:0] data_n, dq_n;
    logic [19:0] addr_n;

    // Chip/byte enables follow Reset directly so they drop the instant Reset is released.
    assign SRAM_CE_N = Reset;
    assign SRAM_UB_N = Reset;
    assign SRAM_LB_N = Reset;

    always_comb begin
        state_n = state;
        armed_n = armed;
        cnt_n   = cnt;
        busy_n  = Busy;
        rdv_n   = 1'b0;
        data_n  = Data_to_CPU;
        addr_n  = SRAM_ADDR;
        dq_n    = SRAM_DQ_out;
        dqoe_n  = SRAM_DQ_oe;
        oen_n   = SRAM_OE_N;
        wen_n   = SRAM_WE_N;

        // Re-arm only once both strobes are seen high, so a held strobe cannot retrigger.
        if (Mem_OE && Mem_WE)
            armed_n = 1'b1;

        case (state)
            IDLE: begin
                if (armed && (!Mem_WE || !Mem_OE)) begin
                    addr_n  = {4'b0, MAR};
                    cnt_n   = WAIT_LD;
                    busy_n  = 1'b1;
                    armed_n = 1'b0;
                    if (!Mem_WE) begin
                        state_n = WRITE;
                        dq_n    = MDR;
                        dqoe_n  = 1'b1;
                        wen_n   = 1'b0;
                    end else begin
                        state_n = READ;
                        oen_n   = 1'b0;
                    end
                end
            end
            READ: begin
                if (cnt == 4'd0) begin
                    data_n  = SRAM_DQ_in;
                    rdv_n   = 1'b1;
                    oen_n   = 1'b1;
                    state_n = RREC;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            WRITE: begin
                if (cnt == 4'd0) begin
                    wen_n   = 1'b1;
                    state_n = WREC;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            // Data stays driven through WREC to give the SRAM hold time after WE_N rises.
            WREC: begin
                dqoe_n  = 1'b0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            RREC: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                oen_n   = 1'b1;
                wen_n   = 1'b1;
                dqoe_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            armed       <= 1'b1;
            cnt         <= 4'd0;
            Busy        <= 1'b0;
            Rd_valid    <= 1'b0;
            Data_to_CPU <= 16'h0;
            SRAM_ADDR   <= 20'h0;
            SRAM_DQ_out <= 16'h0;
            SRAM_DQ_oe  <= 1'b0;
            SRAM_OE_N   <= 1'b1;
            SRAM_WE_N   <= 1'b1;
        end else begin
            state       <= state_n;
            armed       <= armed_n;
            cnt         <= cnt_n;
            Busy        <= busy_n;
            Rd_valid    <= rdv_n;
            Data_to_CPU <= data_n;
            SRAM_ADDR   <= addr_n;
            SRAM_DQ_out <= dq_n;
            SRAM_DQ_oe  <= dqoe_n;
            SRAM_OE_N   <= oen_n;
            SRAM_WE_N   <= wen_n;
        end
    end

`ifdef MEM_SRAM_CTRL_ERR_EN
    logic err_hit;

    // Flags both strobes low together in IDLE, or the active strobe dropping before completion.
    always_comb begin
        err_hit = 1'b0;
        if (state == IDLE && !Mem_OE && !Mem_WE)
            err_hit = 1'b1;
        if (state == READ && Mem_OE)
            err_hit = 1'b1;
        if (state == WRITE && Mem_WE)
            err_hit = 1'b1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            Err <= 1'b0;
        else if (err_hit)
            Err <= 1'b1;
    end
`endif

endmodule
